// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with a per-register busy scoreboard.
//
// Parameters: DATA_W (reg width), ADDR_W (NREG = 2**ADDR_W), NUM_RD (1..4 read
// ports), NUM_WR (1..2 write-back ports). Register 0 reads as zero.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   we/waddr/wdata         per-port write-back (port i at [i*W +: W])
//   re/raddr               per-port read request
//   rdata/rbusy            combinational read data and "awaiting write-back"
//   iss_valid/iss_addr     issued instruction's destination (marks busy)
//   flush                  clears the whole scoreboard
//
// Optional build macro REGFILE_BYPASS_EN: same-cycle write data is forwarded
// to matching reads (highest write port wins) and rbusy is masked for them.
// Without it, reads see stored contents only and rbusy is the raw scoreboard.

module regfile_mp_sb_rd #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic                         rst,
  input  logic                         re,
  input  logic [ADDR_W-1:0]            raddr,
  input  logic [NREG-1:0][DATA_W-1:0]  regs,
  input  logic [NREG-1:0]              busy,
  input  logic                         byp_hit,
  input  logic [DATA_W-1:0]            byp_data,
  output logic [DATA_W-1:0]            rdata,
  output logic                         rbusy
);
  always_comb begin
    rdata = '0;
    rbusy = 1'b0;
    if (!rst && re && raddr != '0) begin
      rdata = byp_hit ? byp_data : regs[raddr];
      // Forwarded data is already available, so the register is not "busy".
      rbusy = busy[raddr] & ~byp_hit;
    end
  end
endmodule

module regfile_mp_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_WR-1:0]          we,
  input  logic [NUM_WR*ADDR_W-1:0]   waddr,
  input  logic [NUM_WR*DATA_W-1:0]   wdata,
  input  logic [NUM_RD-1:0]          re,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rbusy,
  input  logic                       iss_valid,
  input  logic [ADDR_W-1:0]          iss_addr,
  input  logic                       flush
);
  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [NREG-1:0]             busy;

  // Loop order gives the later port the last non-blocking write, so the
  // highest write port wins on an address collision. Issue follows the
  // write-back clears (new producer owns the register), flush follows issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
      busy <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (we[i] && waddr[i*ADDR_W +: ADDR_W] != '0) begin
          regs[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
          busy[waddr[i*ADDR_W +: ADDR_W]] <= 1'b0;
        end
      end
      if (iss_valid && iss_addr != '0) busy[iss_addr] <= 1'b1;
      if (flush) busy <= '0;
    end
  end

  genvar j;
  generate
    for (j = 0; j < NUM_RD; j++) begin : g_rd
      logic              byp_hit;
      logic [DATA_W-1:0] byp_data;

`ifdef REGFILE_BYPASS_EN
      always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        for (int i = 0; i < NUM_WR; i++) begin
          if (we[i] && waddr[i*ADDR_W +: ADDR_W] == raddr[j*ADDR_W +: ADDR_W]
              && raddr[j*ADDR_W +: ADDR_W] != '0) begin
            byp_hit  = 1'b1;
            byp_data = wdata[i*DATA_W +: DATA_W];
          end
        end
      end
`else
      assign byp_hit  = 1'b0;
      assign byp_data = '0;
`endif

      regfile_mp_sb_rd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) u_rd (
        .rst      (rst),
        .re       (re[j]),
        .raddr    (raddr[j*ADDR_W +: ADDR_W]),
        .regs     (regs),
        .busy     (busy),
        .byp_hit  (byp_hit),
        .byp_data (byp_data),
        .rdata    (rdata[j*DATA_W +: DATA_W]),
        .rbusy    (rbusy[j])
      );
    end
  endgenerate
endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;
  localparam int DW = 32, AW = 5, NR = 2, NW = 2, NREG = 32;

  logic             clk = 0;
  logic             rst;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NR-1:0]    re;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic             iss_valid;
  logic [AW-1:0]    iss_addr;
  logic             flush;

  regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .flush(flush)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Architectural model: register values and outstanding-producer flags.
  logic [DW-1:0] m_regs [NREG];
  bit            m_busy [NREG];
  bit            started = 0;

  always @(posedge clk) begin
    if (rst) begin
      started <= 1;
      for (int r = 0; r < NREG; r++) begin m_regs[r] <= '0; m_busy[r] <= 0; end
    end else begin
      for (int i = 0; i < NW; i++)
        if (we[i] && waddr[i*AW +: AW] != 0) begin
          m_regs[waddr[i*AW +: AW]] <= wdata[i*DW +: DW];
          m_busy[waddr[i*AW +: AW]] <= 0;
        end
      if (iss_valid && iss_addr != 0) m_busy[iss_addr] <= 1;
      if (flush) for (int r = 0; r < NREG; r++) m_busy[r] <= 0;
    end
  end

  function automatic logic [DW-1:0] exp_rdata(int j);
    logic [AW-1:0] a = raddr[j*AW +: AW];
    logic [DW-1:0] v;
    if (rst || !re[j] || a == 0) return '0;
    v = m_regs[a];
    if (BYP) for (int i = 0; i < NW; i++)
      if (we[i] && waddr[i*AW +: AW] == a) v = wdata[i*DW +: DW];
    return v;
  endfunction

  function automatic logic exp_rbusy(int j);
    logic [AW-1:0] a = raddr[j*AW +: AW];
    if (rst || !re[j] || a == 0) return 1'b0;
    if (BYP) for (int i = 0; i < NW; i++)
      if (we[i] && waddr[i*AW +: AW] == a) return 1'b0;
    return m_busy[a];
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int j = 0; j < NR; j++) begin
        total++;
        if (rdata[j*DW +: DW] !== exp_rdata(j)) begin
          bad++;
          $display("FAIL model_rdata%0d t=%0t got=%h want=%h", j, $time, rdata[j*DW +: DW], exp_rdata(j));
        end
        total++;
        if (rbusy[j] !== exp_rbusy(j)) begin
          bad++;
          $display("FAIL model_rbusy%0d t=%0t got=%b want=%b", j, $time, rbusy[j], exp_rbusy(j));
        end
      end
    end
  end

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
    iss_valid = 0; iss_addr = '0; flush = 0;
  endtask

  task automatic wr(int i, int a, logic [DW-1:0] d);
    we[i] = 1; waddr[i*AW +: AW] = AW'(a); wdata[i*DW +: DW] = d;
  endtask

  task automatic rd(int j, int a);
    re[j] = 1; raddr[j*AW +: AW] = AW'(a);
  endtask

  task automatic iss(int a);
    iss_valid = 1; iss_addr = AW'(a);
  endtask

  // Advance past the next rising edge; inputs are then driven for the new cycle.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Literal checks sample mid-cycle, away from both clock edges.
  function automatic logic [DW-1:0] rdj(int j); return rdata[j*DW +: DW]; endfunction

  initial begin
    idle(); rst = 1;
    tick(); tick();
    rst = 0;

    // 1: populate, then reset with contents present
    wr(0, 5, 32'hAAAA_5555); wr(1, 3, 32'h3333_0000); iss(2); tick();
    idle(); rd(0, 5); rd(1, 2); #2;
    chk("pre_rst_r5", rdj(0), 32'hAAAA_5555);
    chk("pre_rst_busy2", {31'b0, rbusy[1]}, 32'd1);
    rst = 1; #1;
    chk("rst_rdata0", rdj(0), 32'h0);
    chk("rst_rbusy1", {31'b0, rbusy[1]}, 32'd0);
    tick(); tick();
    rst = 0; idle(); rd(0, 5); rd(1, 2); #2;
    chk("post_rst_r5", rdj(0), 32'h0);
    chk("post_rst_busy2", {31'b0, rbusy[1]}, 32'd0);

    // 2: basic write/read, r0 hardwired, read-enable gating
    idle(); wr(0, 3, 32'hDEAD_BEEF); tick();
    idle(); rd(0, 3); raddr[AW +: AW] = 5'd3; #2;
    chk("r3_read", rdj(0), 32'hDEAD_BEEF);
    chk("re_off_zero", rdj(1), 32'h0);
    idle(); wr(1, 0, 32'h1234); tick();
    idle(); rd(0, 0); #2;
    chk("r0_zero", rdj(0), 32'h0);

    // 3: same-address dual write, higher port wins; bypass vs stored
    idle(); wr(0, 7, 32'h99); tick();
    idle(); wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(0, 7); rd(1, 7); #2;
    chk("r7_same_cycle", rdj(0), BYP ? 32'h22 : 32'h99);
    tick();
    idle(); rd(0, 7); #2;
    chk("r7_next", rdj(0), 32'h22);

    // 4: issue marks busy, write-back clears it
    idle(); iss(9); tick();
    idle(); rd(0, 9); #2;
    chk("busy9_set", {31'b0, rbusy[0]}, 32'd1);
    idle(); wr(1, 9, 32'h55); rd(0, 9); #2;
    chk("busy9_wb_cycle", {31'b0, rbusy[0]}, BYP ? 32'd0 : 32'd1);
    chk("r9_wb_cycle", rdj(0), BYP ? 32'h55 : 32'h0);
    tick();
    idle(); rd(0, 9); #2;
    chk("busy9_clear", {31'b0, rbusy[0]}, 32'd0);
    chk("r9_after", rdj(0), 32'h55);

    // 5: issue beats same-cycle write-back; flush beats issue
    idle(); iss(4); wr(0, 4, 32'h44); tick();
    idle(); rd(1, 4); #2;
    chk("busy4_issue_wins", {31'b0, rbusy[1]}, 32'd1);
    idle(); iss(4); wr(0, 4, 32'h45); flush = 1; tick();
    idle(); rd(1, 4); #2;
    chk("busy4_flush_wins", {31'b0, rbusy[1]}, 32'd0);
    chk("r4_written", rdj(1), 32'h45);

    // 6: multiple busy then flush; reset mid-sequence
    idle(); iss(2); tick();
    idle(); iss(6); tick();
    idle(); iss(10); tick();
    idle(); rd(0, 2); rd(1, 10); #2;
    chk("busy2", {31'b0, rbusy[0]}, 32'd1);
    chk("busy10", {31'b0, rbusy[1]}, 32'd1);
    idle(); flush = 1; tick();
    idle(); rd(0, 6); rd(1, 10); #2;
    chk("flush_busy6", {31'b0, rbusy[0]}, 32'd0);
    chk("flush_busy10", {31'b0, rbusy[1]}, 32'd0);
    idle(); iss(12); wr(0, 13, 32'hCAFE); tick();
    idle(); rst = 1; iss(14); wr(1, 13, 32'hF00D); tick();
    rst = 0; idle(); rd(0, 13); rd(1, 12); #2;
    chk("rst_mid_r13", rdj(0), 32'h0);
    chk("rst_mid_busy12", {31'b0, rbusy[1]}, 32'd0);
    idle(); rd(0, 7); rd(1, 14); #2;
    chk("rst_mid_r7", rdj(0), 32'h0);
    chk("rst_mid_busy14", {31'b0, rbusy[1]}, 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port general-purpose register file with a per-register busy scoreboard.
- Next-generation replacement for the 2-read/1-write register file in the ID stage.
- Supports NUM_RD read ports and NUM_WR write-back ports, configurable write-to-read bypass, and producer tracking so the issue logic can detect RAW hazards without external bookkeeping.
- Register 0 is hardwired to zero.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; NREG = 2**ADDR_W registers
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 2, number of write-back ports (1..2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
we  input  NUM_WR  per-port write enable
waddr  input  NUM_WR*ADDR_W  write addresses, port i at [i*ADDR_W +: ADDR_W]
wdata  input  NUM_WR*DATA_W  write data, port i at [i*DATA_W +: DATA_W]
re  input  NUM_RD  per-port read enable
raddr  input  NUM_RD*ADDR_W  read addresses, packed as for waddr
rdata  output  NUM_RD*DATA_W  read data, packed
rbusy  output  NUM_RD  1 = register addressed by read port is awaiting a write-back
iss_valid  input  1  instruction issued with a destination register
iss_addr  input  ADDR_W  destination register of the issued instruction
flush  input  1  clear the entire scoreboard (pipeline flush)

Behaviour:
- Reset: all registers cleared to 0 and all busy bits cleared on the clock edge with rst=1. While rst=1, rdata=0 and rbusy=0 for every port (combinational).
- Write: on a rising edge, for each i with we[i]=1 and waddr[i]!=0, regs[waddr[i]] <= wdata[i].
  - Two ports writing the same address: the higher port index wins.
  - Writes to address 0 are discarded.
- Read (combinational, zero latency):
  - re[j]=0 -> rdata_j=0.
  - raddr_j=0 -> rdata_j=0.
  - Otherwise rdata_j = regs[raddr_j], subject to the bypass rule in Optional Feature.
- Scoreboard: busy[NREG-1:1]; busy[0] is constant 0. Per edge, evaluated in this order, later rules overriding earlier ones:
  1. For each i with we[i]=1 and waddr[i]!=0: busy[waddr[i]] <= 0.
  2. If iss_valid=1 and iss_addr!=0: busy[iss_addr] <= 1. Issue beats a same-cycle write-back to the same register, because the new producer owns it.
  3. If flush=1: all busy <= 0. Flush overrides issue in the same cycle.
- rbusy_j = re[j] & busy[raddr_j], taken from the registered scoreboard (no same-cycle bypass of iss_valid).
  - With the bypass enabled, rbusy_j is additionally forced to 0 when a same-cycle write port matches raddr_j, because the data is already available.
- Each read port is independent, and any number of read ports may address the same register.
- No stall or backpressure; every cycle accepts writes and an issue.

Optional Feature:
Macro: REGFILE_BYPASS_EN
- Defined: a read port matching an active same-cycle write (we[i]=1, waddr[i]=raddr_j!=0, re[j]=1) returns wdata[i]. The highest matching port index wins, and rbusy_j is masked to 0.
- Undefined: reads always return stored regs content, so a new value is visible the cycle after the write. rbusy_j is taken from the scoreboard unmasked. This saves the comparators on the timing path.

Test Plan:
1. rst=1 for 2 cycles with prior contents -> all rdata=0 and rbusy=0; after release, reading r5 returns 0.
2. Write r3=0xDEADBEEF on port 0; next cycle re[0]=1, raddr=3 -> rdata_0=0xDEADBEEF. Write r0=0x1234 -> reading r0 returns 0.
3. Same cycle: port 0 writes r7=0x11, port 1 writes r7=0x22 -> next cycle r7 reads 0x22. With REGFILE_BYPASS_EN, the same-cycle read of r7 returns 0x22; without it, the same-cycle read returns the old value.
4. iss_valid with iss_addr=9 -> next cycle rbusy for raddr=9 is 1. Write-back r9=0x55 clears it the following cycle. With bypass, rbusy is 0 already in the write-back cycle and rdata=0x55.
5. Same cycle: iss_valid with iss_addr=4 and we[0]=1 writing r4 -> busy[4]=1 afterward. Add flush in the same cycle -> busy[4]=0.
6. Set busy on r2, r6 and r10, then flush=1 -> all rbusy=0 next cycle. Assert rst mid-sequence -> registers and scoreboard all zero.
